// File: rtl/cnt_seq_ctrl_if.sv
// Command port of the counter sequencer: one opcode plus operand per valid/ready handshake.
// A command transfers on a rising clk edge where cmd_valid && cmd_ready; the master holds op/data stable while valid is high.
interface cnt_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/cnt_seq_ctrl.sv
// Command-driven sequencer for the 8-bit counter datapath: load, step, one-shot and looping runs.
// Optional sticky error flag for commands dropped while running: define CNT_SEQ_ERR_EN.
module cnt_seq_ctrl #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  cnt_seq_ctrl_if.slave    cmd,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             cnt_en,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_load_val,
  output logic             cnt_up,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
`ifdef CNT_SEQ_ERR_EN
  , output logic           err
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, LOOP = 2'd2} state_e;
  typedef enum logic [2:0] {
    OP_NOP = 3'd0, OP_LOAD = 3'd1, OP_SET_LIMIT = 3'd2, OP_SET_PRESCALE = 3'd3,
    OP_RUN_ONCE = 3'd4, OP_RUN_LOOP = 3'd5, OP_STOP = 3'd6, OP_STEP = 3'd7
  } op_e;

  localparam logic [WIDTH-1:0]      ONE_W = 1;
  localparam logic [PRESCALE_W-1:0] ONE_P = 1;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      start_q, start_d;
  logic [WIDTH-1:0]      limit_q, limit_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d;
  logic                  en_q, en_d;
  logic                  load_q, load_d;
  logic [WIDTH-1:0]      load_val_q, load_val_d;
  logic                  up_q, up_d;
  logic                  done_q, done_d;

  op_e                   op;
  logic                  hs;
  logic                  tick;
  logic [WIDTH-1:0]      eff_value;
  logic [PRESCALE_W-1:0] presc_data;

  assign cmd.cmd_ready = 1'b1;
  assign hs            = cmd.cmd_valid;
  assign op            = op_e'(cmd.cmd_op);

  generate
    if (PRESCALE_W > WIDTH) begin : g_presc_ext
      assign presc_data = {{(PRESCALE_W-WIDTH){1'b0}}, cmd.cmd_data};
    end else begin : g_presc_trunc
      assign presc_data = cmd.cmd_data[PRESCALE_W-1:0];
    end
  endgenerate

  // cnt_value lags our own registered step/load by one edge; compare against the value it is about to take.
  always_comb begin
    eff_value = cnt_value;
    if (load_q)    eff_value = load_val_q;
    else if (en_q) eff_value = up_q ? (cnt_value + ONE_W) : (cnt_value - ONE_W);
  end

  assign tick = (state_q != IDLE) && (presc_cnt_q == presc_q);

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    limit_d     = limit_q;
    presc_d     = presc_q;
    presc_cnt_d = presc_cnt_q;
    en_d        = 1'b0;
    load_d      = 1'b0;
    load_val_d  = load_val_q;
    up_d        = up_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs) begin
          case (op)
            OP_LOAD: begin
              start_d    = cmd.cmd_data;
              load_d     = 1'b1;
              load_val_d = cmd.cmd_data;
            end
            OP_SET_LIMIT:    limit_d = cmd.cmd_data;
            OP_SET_PRESCALE: presc_d = presc_data;
            OP_RUN_ONCE, OP_RUN_LOOP: begin
              up_d        = cmd.cmd_data[0];
              presc_cnt_d = '0;
              state_d     = (op == OP_RUN_ONCE) ? RUN : LOOP;
            end
            OP_STEP: begin
              en_d = 1'b1;
              up_d = cmd.cmd_data[0];
            end
            default: ;
          endcase
        end
      end
      RUN, LOOP: begin
        presc_cnt_d = tick ? '0 : (presc_cnt_q + ONE_P);
        if (tick) begin
          if (eff_value != limit_q) begin
            en_d = 1'b1;
          end else if (state_q == RUN) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            load_d     = 1'b1;
            load_val_d = start_q;
          end
        end
        // STOP overrides whatever the tick decided this cycle.
        if (hs && (op == OP_STOP)) begin
          state_d    = IDLE;
          en_d       = 1'b0;
          load_d     = 1'b0;
          load_val_d = load_val_q;
          done_d     = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      start_q     <= '0;
      limit_q     <= '1;
      presc_q     <= '0;
      presc_cnt_q <= '0;
      en_q        <= 1'b0;
      load_q      <= 1'b0;
      load_val_q  <= '0;
      up_q        <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      limit_q     <= limit_d;
      presc_q     <= presc_d;
      presc_cnt_q <= presc_cnt_d;
      en_q        <= en_d;
      load_q      <= load_d;
      load_val_q  <= load_val_d;
      up_q        <= up_d;
      done_q      <= done_d;
    end
  end

  assign cnt_en       = en_q;
  assign cnt_load     = load_q;
  assign cnt_load_val = load_val_q;
  assign cnt_up       = up_q;
  assign done         = done_q;
  assign busy         = (state_q != IDLE);
  assign state        = state_q;

`ifdef CNT_SEQ_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (hs) begin
      if ((state_q == IDLE) && (op == OP_NOP))
        err_d = 1'b0;
      else if ((state_q != IDLE) && (op != OP_NOP) && (op != OP_STOP))
        err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Directed bench for cnt_seq_ctrl: idle-command vector table plus hand-written run/loop/stop/reset sequences.
// The counter datapath is modelled here so the sequencer sees a live cnt_value.
module tb_cnt_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cnt_q = 8'h00;
  logic       cnt_en, cnt_load, cnt_up, busy, done;
  logic [7:0] cnt_load_val;
  logic [1:0] state;
`ifdef CNT_SEQ_ERR_EN
  logic       err;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  cnt_seq_ctrl_if #(.WIDTH(8)) cmd_if ();

  cnt_seq_ctrl #(.WIDTH(8), .PRESCALE_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd          (cmd_if),
    .cnt_value    (cnt_q),
    .cnt_en       (cnt_en),
    .cnt_load     (cnt_load),
    .cnt_load_val (cnt_load_val),
    .cnt_up       (cnt_up),
    .busy         (busy),
    .done         (done),
    .state        (state)
`ifdef CNT_SEQ_ERR_EN
    , .err        (err)
`endif
  );

  // clock and counter datapath
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (cnt_load)    cnt_q <= cnt_load_val;
    else if (cnt_en) cnt_q <= cnt_up ? (cnt_q + 8'd1) : (cnt_q - 8'd1);
  end

  typedef struct {
    logic [2:0] op;
    logic [7:0] data;
    logic       exp_load;
    logic [7:0] exp_val;
    logic       exp_en;
    logic       exp_up;
    logic [1:0] exp_state;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // drive one command; returns #1 after the handshake edge
  task automatic send(input logic [2:0] op, input logic [7:0] data);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = data;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 3'd0;
    cmd_if.cmd_data  = 8'h00;
  endtask

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  // bit i of each trace holds the output i cycles after the call
  task automatic trace(input int n, output logic [31:0] en_t, output logic [31:0] load_t,
                       output logic [31:0] done_t);
    en_t = '0; load_t = '0; done_t = '0;
    for (int i = 0; i < n; i++) begin
      en_t[i]   = cnt_en;
      load_t[i] = cnt_load;
      done_t[i] = done;
      step_cycle();
    end
  endtask

  initial begin
    logic [31:0] en_t, load_t, done_t;
    logic        pend;
    logic        found;

    vecs[0] = '{3'd1, 8'h05, 1'b1, 8'h05, 1'b0, 1'b1, 2'd0};
    vecs[1] = '{3'd0, 8'h00, 1'b0, 8'h05, 1'b0, 1'b1, 2'd0};
    vecs[2] = '{3'd7, 8'h00, 1'b0, 8'h05, 1'b1, 1'b0, 2'd0};
    vecs[3] = '{3'd7, 8'h01, 1'b0, 8'h05, 1'b1, 1'b1, 2'd0};
    vecs[4] = '{3'd2, 8'h08, 1'b0, 8'h05, 1'b0, 1'b1, 2'd0};
    vecs[5] = '{3'd3, 8'h00, 1'b0, 8'h05, 1'b0, 1'b1, 2'd0};
    vecs[6] = '{3'd6, 8'h00, 1'b0, 8'h05, 1'b0, 1'b1, 2'd0};
    vecs[7] = '{3'd1, 8'h05, 1'b1, 8'h05, 1'b0, 1'b1, 2'd0};

    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 3'd0;
    cmd_if.cmd_data  = 8'h00;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst cnt_en", cnt_en, 0);
    check("rst cnt_load", cnt_load, 0);
    check("rst cnt_load_val", cnt_load_val, 0);
    check("rst cnt_up", cnt_up, 1);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst state", state, 0);
    check("cmd_ready", cmd_if.cmd_ready, 1);
`ifdef CNT_SEQ_ERR_EN
    check("rst err", err, 0);
`endif
    rst_n = 1'b1;
    step_cycle();

    // idle command table
    for (int v = 0; v < 8; v++) begin
      send(vecs[v].op, vecs[v].data);
      check($sformatf("vec%0d cnt_load", v), cnt_load, vecs[v].exp_load);
      check($sformatf("vec%0d cnt_load_val", v), cnt_load_val, vecs[v].exp_val);
      check($sformatf("vec%0d cnt_en", v), cnt_en, vecs[v].exp_en);
      check($sformatf("vec%0d cnt_up", v), cnt_up, vecs[v].exp_up);
      check($sformatf("vec%0d state", v), state, vecs[v].exp_state);
    end
    step_cycle();
    check("table pulse drop", cnt_load, 0);
    check("table cnt_value", cnt_q, 8'h05);

    // one-shot up 5 -> 8, prescale 0
    send(3'd4, 8'h01);
    check("once state run", state, 1);
    check("once busy", busy, 1);
    trace(6, en_t, load_t, done_t);
    check("once en trace", en_t, 32'b001110);
    check("once done trace", done_t, 32'b010000);
    check("once load trace", load_t, 0);
    check("once end state", state, 0);
    check("once end value", cnt_q, 8'h08);

    // loop with prescale 3: 0,1,2,0,1 then STOP on a tick
    send(3'd3, 8'h03);
    send(3'd1, 8'h00);
    send(3'd2, 8'h02);
    send(3'd5, 8'h01);
    check("loop state", state, 2);
    exp_q = '{8'h01, 8'h02, 8'h00, 8'h01};
    en_t = '0; load_t = '0; done_t = '0;
    pend = 1'b0;
    for (int i = 0; i < 19; i++) begin
      if (pend) begin
        if (exp_q.size() == 0) check("loop seq extra step", 1, 0);
        else check($sformatf("loop seq c%0d", i + 1), cnt_q, exp_q.pop_front());
      end
      en_t[i]   = cnt_en;
      load_t[i] = cnt_load;
      done_t[i] = done;
      if (cnt_load) check("loop reload val", cnt_load_val, 8'h00);
      pend = cnt_en | cnt_load;
      step_cycle();
    end
    check("loop seq left", exp_q.size(), 0);
    check("loop en trace", en_t, (32'd1 << 4) | (32'd1 << 8) | (32'd1 << 16));
    check("loop load trace", load_t, 32'd1 << 12);
    check("loop done trace", done_t, 0);
    send(3'd6, 8'h00);
    check("stop state", state, 0);
    check("stop cnt_en", cnt_en, 0);
    check("stop cnt_load", cnt_load, 0);
    trace(8, en_t, load_t, done_t);
    check("after stop en", en_t, 0);
    check("after stop load", load_t, 0);
    check("after stop done", done_t, 0);

    // STOP in the cycle the limit is hit
    send(3'd5, 8'h01);
    repeat (7) step_cycle();
    send(3'd6, 8'h00);
    check("stop@limit load", cnt_load, 0);
    check("stop@limit done", done, 0);
    check("stop@limit state", state, 0);
    step_cycle();
    check("stop@limit load2", cnt_load, 0);
    check("stop@limit value", cnt_q, 8'h02);

    // one-shot down through the wrap: 1,0,FF,FE
    send(3'd3, 8'h00);
    send(3'd1, 8'h01);
    send(3'd2, 8'hFE);
    send(3'd4, 8'h00);
    check("wrap cnt_up", cnt_up, 0);
    trace(6, en_t, load_t, done_t);
    check("wrap en trace", en_t, 32'b001110);
    check("wrap done trace", done_t, 32'b010000);
    check("wrap end value", cnt_q, 8'hFE);

    // reset mid-run
    send(3'd1, 8'h10);
    send(3'd2, 8'h80);
    send(3'd4, 8'h01);
    step_cycle();
    step_cycle();
    rst_n = 1'b0;
    step_cycle();
    rst_n = 1'b1;
    check("midrst cnt_en", cnt_en, 0);
    check("midrst cnt_load", cnt_load, 0);
    check("midrst cnt_load_val", cnt_load_val, 0);
    check("midrst cnt_up", cnt_up, 1);
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst state", state, 0);
    trace(5, en_t, load_t, done_t);
    check("midrst no done", done_t, 0);
    check("midrst no en", en_t, 0);
    // limit back to FF and prescale 0: FD -> FF in two back-to-back steps
    send(3'd1, 8'hFD);
    send(3'd4, 8'h01);
    trace(5, en_t, load_t, done_t);
    check("rstval en trace", en_t, 32'b00110);
    check("rstval done trace", done_t, 32'b01000);
    check("rstval end value", cnt_q, 8'hFF);

    // command other than STOP/NOP while looping is dropped
    send(3'd2, 8'h03);
    send(3'd1, 8'h00);
    send(3'd5, 8'h01);
    send(3'd1, 8'h07);
    check("drop cnt_load", cnt_load, 0);
`ifdef CNT_SEQ_ERR_EN
    check("err set", err, 1);
`endif
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      if (cnt_load) found = 1'b1;
      else step_cycle();
    end
    check("drop reload seen", found, 1);
    if (found) check("drop start kept", cnt_load_val, 8'h00);
    send(3'd6, 8'h00);
    check("drop stop state", state, 0);
`ifdef CNT_SEQ_ERR_EN
    check("err sticky", err, 1);
    send(3'd0, 8'h00);
    check("err cleared", err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
